uart_rx_fifo: RTL and testbench

- Byte FIFO that sits directly downstream of the UART receiver and upstream of the transmitter and segment display.
- Absorbs bursts of received bytes, signalled by the receiver's one-cycle done strobe, so that no byte is lost while the transmitter is busy.
- Presents bytes on a first-word-fall-through valid/ready interface.
- Reports fill level and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_fifo.sv | 102 ++++++++++
 tb/tb_uart_rx_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive path blocks.
//   BYTE_W          : width of one UART character
//   byte_t          : one UART character
//   UART_FIFO_DEPTH : default depth of the receive byte FIFO
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    localparam int UART_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and its consumers
// (transmitter, segment display). Absorbs bursts of received bytes so none
// are lost while the consumer is busy, and presents them first-word-fall-through.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   wr_data  : byte from the receiver, taken when wr_en=1
//   wr_en    : receiver done strobe, one byte per high cycle
//   rd_data  : head-of-queue byte, meaningful when rd_valid=1
//   rd_valid : FIFO holds at least one byte
//   rd_ready : consumer takes the head byte when rd_valid & rd_ready
//   count    : number of stored bytes, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
//   overflow : sticky, set when a write was dropped because the FIFO was full
//   ovf_clr  : synchronous clear of overflow (a same-cycle new overflow wins)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = BYTE_W,
    parameter  int DEPTH  = UART_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              ovf_clr
);

    // One extra pointer bit distinguishes full from empty when the
    // storage indices coincide.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    logic do_read;
    logic do_write;
    logic ovf_event;

    // Status comes from registered pointers only, so no input reaches an
    // output combinationally.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                      (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign rd_valid = !empty;
    assign rd_data  = mem[rd_ptr[ADDR_W-1:0]];

    // A read in the same cycle frees the slot the full-FIFO write lands in,
    // so a write is accepted when full as long as a read also happens.
    assign do_read   = rd_valid && rd_ready;
    assign do_write  = wr_en && (!full || do_read);
    assign ovf_event = wr_en && full && !do_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Writes only ever target the wr_ptr slot, which is the head slot only
    // when empty or when full-with-read, so rd_data holds while the head
    // byte waits for rd_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // New overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the FIFO.
module tb_uart_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              ovf_clr;

    int n_checks;
    int n_pass;

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of bytes plus a sticky overflow bit.
    logic [DATA_W-1:0] model_q[$];
    logic              model_ovf;

    initial model_ovf = 1'b0;

    always @(posedge clk) begin
        bit rd_ok;
        bit wr_ok;
        bit ovf_ev;
        if (rst) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            rd_ok  = (model_q.size() != 0) && rd_ready;
            wr_ok  = wr_en && ((model_q.size() < DEPTH) || rd_ok);
            ovf_ev = wr_en && (model_q.size() == DEPTH) && !rd_ok;
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(wr_data);
            if (ovf_ev)       model_ovf = 1'b1;
            else if (ovf_clr) model_ovf = 1'b0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count",    int'(count),    model_q.size());
            chk("rd_valid", int'(rd_valid), int'(model_q.size() != 0));
            chk("empty",    int'(empty),    int'(model_q.size() == 0));
            chk("full",     int'(full),     int'(model_q.size() == DEPTH));
            chk("overflow", int'(overflow), int'(model_ovf));
            if (model_q.size() != 0) begin
                chk("rd_data", int'(rd_data), int'(model_q[0]));
            end
        end
    end

    // Drive one cycle of inputs from a negedge; return at the next negedge.
    task automatic step(input logic we, input logic [DATA_W-1:0] wd,
                        input logic rr, input logic clr);
        wr_en    = we;
        wr_data  = wd;
        rd_ready = rr;
        ovf_clr  = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_seq [3];
        int written;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;

        // Reset state
        #3;
        chk("rst_count",    int'(count),    0);
        chk("rst_empty",    int'(empty),    1);
        chk("rst_full",     int'(full),     0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_rd_data",  int'(rd_data),  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Three writes, then three reads
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("fwft_latency", int'(rd_data), 'h41);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("three_count", int'(count), 3);
        exp_seq[0] = 8'h41;
        exp_seq[1] = 8'h42;
        exp_seq[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            chk("three_read", int'(rd_data), int'(exp_seq[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("three_empty", int'(empty), 1);

        // Fill, overflow, drain, clear
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full",  int'(full),  1);
        chk("fill_count", int'(count), 16);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set",   int'(overflow), 1);
        chk("ovf_count", int'(count),    16);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", int'(rd_data), i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", int'(empty),    1);
        chk("ovf_sticky",  int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", int'(overflow), 0);

        // Full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw_count", int'(count),    16);
        chk("full_rw_ovf",   int'(overflow), 0);
        chk("full_rw_head",  int'(rd_data),  'h11);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rw_aa", int'(rd_data), 'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rw_empty", int'(empty), 1);

        // Randomized interleaved traffic, at least 40 writes offered
        written = 0;
        for (int c = 0; c < 400 && written < 40; c++) begin
            logic we;
            we = ($urandom_range(0, 3) != 0);
            if (we) written++;
            step(we, 8'($urandom), 1'($urandom), 1'b0);
        end
        for (int c = 0; c < 200; c++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
        end
        for (int c = 0; c < DEPTH + 1; c++) step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("rand_drained", int'(empty), 1);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        chk("post_rst_head",  int'(rd_data), 'h55);
        chk("post_rst_count", int'(count),   1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo
